// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_dbg_pkg
//  Description : Shared constants and state encoding for the register
//                snapshot streamer (frame geometry, header byte, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_dbg_pkg;

    // Default first byte of every frame
    localparam logic [7:0] c_header_default = 8'hA5;

    // Frame geometry: header + 33 big-endian words + checksum
    localparam int c_frame_bytes   = 134;
    localparam int c_payload_bytes = 132;

    // Index of the last payload byte; its transfer moves on to the checksum
    localparam logic [7:0] c_last_payload_idx = 8'(c_payload_bytes - 1);

    // Streamer FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle     = 2'd0;
    localparam state_t c_st_header   = 2'd1;
    localparam state_t c_st_payload  = 2'd2;
    localparam state_t c_st_checksum = 2'd3;

endpackage : mips_dbg_pkg
`default_nettype wire

// File: rtl/snapshot_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : snapshot_buffer
//  Description : 33 x 32-bit capture register holding PC and r0..r31, with a
//                combinational big-endian byte read port addressed by the
//                payload byte index.
//  Revision    : 1.0 - initial release
// ============================================================================
module snapshot_buffer #(
    parameter int NUM_REGS = 32
) (
    input  logic                     clk,
    input  logic                     capture,
    input  logic [31:0]              pc_in,
    input  logic [32*NUM_REGS-1:0]   regs_flat,
    input  logic [7:0]               rd_idx,
    output logic [7:0]               rd_byte
);

    // Word 0 is the PC, words 1..NUM_REGS are r0..r(NUM_REGS-1)
    localparam logic [5:0] c_last_word = 6'(NUM_REGS);

    logic [31:0] r_words [0:NUM_REGS];
    logic [5:0]  w_word_sel;
    logic [31:0] w_word;

    // Capture the whole architectural state in one cycle; contents are
    // don't-care out of reset, so no reset is applied
    always_ff @(posedge clk) begin
        if (capture) begin
            r_words[0] <= pc_in;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_words[i+1] <= regs_flat[32*i +: 32];
            end
        end
    end

    // Byte read: word = idx>>2, byte lane 3-(idx&3) so bits 31:24 go first;
    // indices past the last word read as zero
    always_comb begin
        w_word_sel = rd_idx[7:2];
        w_word     = 32'd0;
        if (w_word_sel <= c_last_word) begin
            w_word = r_words[w_word_sel];
        end
        case (rd_idx[1:0])
            2'd0:    rd_byte = w_word[31:24];
            2'd1:    rd_byte = w_word[23:16];
            2'd2:    rd_byte = w_word[15:8];
            default: rd_byte = w_word[7:0];
        endcase
    end

endmodule : snapshot_buffer
`default_nettype wire

// File: rtl/reg_snapshot_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_snapshot_streamer
//  Description : Captures PC + r0..r31 on request and streams a framed byte
//                sequence (header, 132 payload bytes, XOR checksum) over a
//                valid/ready interface. Requests while busy are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_snapshot_streamer
    import mips_dbg_pkg::*;
#(
    parameter logic [7:0] HEADER   = c_header_default,
    parameter int         NUM_REGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_in,
    input  logic [32*NUM_REGS-1:0]   regs_flat,
    input  logic                     snap_req,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               drop_cnt
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_idx;
    logic [7:0] r_csum;
    logic [7:0] r_out_data;
    logic       r_frame_done;
    logic [7:0] r_drop_cnt;

    logic       w_valid;
    logic       w_busy;
    logic       w_capture;
    logic       w_xfer;
    logic [7:0] w_rd_idx;
    logic [7:0] w_rd_byte;

    snapshot_buffer #(
        .NUM_REGS (NUM_REGS)
    ) u_snapshot_buffer (
        .clk       (clk),
        .capture   (w_capture),
        .pc_in     (pc_in),
        .regs_flat (regs_flat),
        .rd_idx    (w_rd_idx),
        .rd_byte   (w_rd_byte)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: advance only on an accepted byte
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:     if (snap_req) w_state_next = c_st_header;
            c_st_header:   if (w_xfer)   w_state_next = c_st_payload;
            c_st_payload:  if (w_xfer && (r_idx == c_last_payload_idx))
                               w_state_next = c_st_checksum;
            c_st_checksum: if (w_xfer)   w_state_next = c_st_idle;
            default:       w_state_next = c_st_idle;
        endcase
    end

    // State-decoded outputs; valid and busy come straight from the state flops
    always_comb begin
        w_valid   = (r_state != c_st_idle);
        w_busy    = (r_state != c_st_idle);
        w_capture = (r_state == c_st_idle) && snap_req;
        w_xfer    = w_valid && out_ready;
        // Prefetch the byte that will be presented after the next transfer
        w_rd_idx  = (r_state == c_st_header) ? 8'd0 : (r_idx + 8'd1);
    end

    // Output byte register, payload index and running checksum
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_data   <= 8'd0;
            r_idx        <= 8'd0;
            r_csum       <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (snap_req) begin
                        r_out_data <= HEADER;
                        r_idx      <= 8'd0;
                        r_csum     <= 8'd0;
                    end
                end
                c_st_header: begin
                    if (w_xfer) begin
                        r_out_data <= w_rd_byte;
                        r_idx      <= 8'd0;
                    end
                end
                c_st_payload: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ r_out_data;
                        r_idx  <= r_idx + 8'd1;
                        // Last payload byte: the checksum including it goes out next
                        if (r_idx == c_last_payload_idx) begin
                            r_out_data <= r_csum ^ r_out_data;
                        end else begin
                            r_out_data <= w_rd_byte;
                        end
                    end
                end
                c_st_checksum: begin
                    if (w_xfer) begin
                        r_out_data   <= 8'd0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_out_data <= 8'd0;
                end
            endcase
        end
    end

    // Saturating count of requests that arrive while a frame is in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_busy && snap_req && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = w_valid;
    assign busy       = w_busy;
    assign frame_done = r_frame_done;
    assign drop_cnt   = r_drop_cnt;

endmodule : reg_snapshot_streamer
`default_nettype wire

// File: tb/tb_reg_snapshot_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_snapshot_streamer
//  Description : Self-checking bench for reg_snapshot_streamer. Expected
//                frames are queued when a request is issued and compared
//                byte by byte as the stream is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_snapshot_streamer;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_in;
    logic [1023:0] regs_flat;
    logic          snap_req;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          frame_done;
    logic [7:0]    drop_cnt;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         frame_pos = 0;
    bit         exp_fd = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] last_csum = 8'd0;

    always #5 clk = ~clk;

    reg_snapshot_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .regs_flat  (regs_flat),
        .snap_req   (snap_req),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the frame expected from the inputs currently applied
    task automatic push_frame();
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'd0;
        q.push_back('{8'hA5, 1'b0});
        for (int wi = 0; wi < 33; wi++) begin
            w = (wi == 0) ? pc_in : regs_flat[32*(wi-1) +: 32];
            for (int k = 3; k >= 0; k--) begin
                cs = cs ^ w[8*k +: 8];
                q.push_back('{w[8*k +: 8], 1'b0});
            end
        end
        q.push_back('{cs, 1'b1});
    endtask

    task automatic pulse_req();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) timeout(tag);
        repeat (2) tick();
    endtask

    task automatic wait_pos(input int target, input string tag);
        int n;
        n = 0;
        while (frame_pos != target && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) timeout(tag);
    endtask

    task automatic set_pattern();
        pc_in = 32'h0040_0000;
        for (int i = 0; i < 32; i++) regs_flat[32*i +: 32] = 32'(i);
    endtask

    // Stream monitor: handshake stability, scoreboard pop, frame_done timing
    always @(negedge clk) begin
        if (rst) begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            exp_fd = 0;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL extra_byte observed=%0h expected=none", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("stream_byte", {24'd0, out_data}, {24'd0, e.b});
                    frame_pos++;
                    if (e.last) begin
                        exp_fd    = 1;
                        last_csum = out_data;
                        frame_pos = 0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            exp_fd     = 0;
            prev_stall = 0;
            frame_pos  = 0;
        end
    end

    initial begin
        int n;
        rst       = 1'b0;
        snap_req  = 1'b0;
        out_ready = 1'b1;
        pc_in     = 32'd0;
        regs_flat = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        // Zero snapshot: busy spans exactly 134 cycles
        push_frame();
        pulse_req();
        chk("zero_hdr", {24'd0, out_data}, 32'hA5);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
        chk("zero_busy_span", 32'(n), 32'd134);
        wait_idle("zero_frame");
        chk("zero_drained", 32'(q.size()), 32'd0);

        // Pattern snapshot
        set_pattern();
        push_frame();
        pulse_req();
        wait_idle("pattern_frame");
        chk("pattern_csum", {24'd0, last_csum}, 32'h40);

        // Back-pressure while payload byte 10 is presented
        push_frame();
        pulse_req();
        wait_pos(11, "bp_wait");
        out_ready = 1'b0;
        repeat (5) tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_idle("bp_frame");
        chk("bp_csum", {24'd0, last_csum}, 32'h40);

        // Isolation and dropped requests
        push_frame();
        pulse_req();
        repeat (3) tick();
        regs_flat = '1;
        repeat (3) begin
            pulse_req();
            tick();
        end
        chk("drop_three", {24'd0, drop_cnt}, 32'd3);
        out_ready = 1'b0;
        snap_req  = 1'b1;
        repeat (300) tick();
        snap_req  = 1'b0;
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
        out_ready = 1'b1;
        wait_idle("iso_frame");
        chk("iso_csum", {24'd0, last_csum}, 32'h40);

        // Reset abort at payload byte 50, then a fresh frame
        push_frame();
        pulse_req();
        wait_pos(51, "abort_wait");
        rst = 1'b0;
        tick();
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_drop", {24'd0, drop_cnt}, 32'd0);
        q.delete();
        rst = 1'b1;
        tick();
        push_frame();
        pulse_req();
        wait_idle("fresh_frame");

        // Back-to-back with request held high
        set_pattern();
        push_frame();
        push_frame();
        snap_req = 1'b1;
        tick();
        n = 0;
        while (!frame_done && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeout("b2b_done");
        chk("b2b_bubble", {31'd0, out_valid}, 32'd0);
        chk("b2b_drop", {24'd0, drop_cnt}, 32'd134);
        tick();
        snap_req = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_hdr", {24'd0, out_data}, 32'hA5);
        wait_idle("b2b_frame");
        chk("b2b_drop_final", {24'd0, drop_cnt}, 32'd134);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_snapshot_streamer
`default_nettype wire

// File: doc/reg_snapshot_streamer.md
Name: reg_snapshot_streamer

Overview:
Debug-side consumer of the pipeline's architectural-state outputs: the program counter and register-file words r0..r31. On a request it captures one coherent snapshot of all 33 words in a single cycle. It then serialises the snapshot as a framed byte stream over a valid/ready interface, e.g. toward a UART transmitter or a JTAG FIFO. It sits beside the processor top level and never back-pressures the pipeline.

Parameters:
HEADER, 8'hA5, first byte of every frame
NUM_REGS, 32, register words captured after the PC (fixed at 32 for this core)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
pc_in  in  32  current program counter
regs_flat  in  1024  register file, word n at [32n+31:32n]
snap_req  in  1  single-cycle capture request
out_data  out  8  stream byte
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts the byte this cycle
busy  out  1  frame in progress (capture through checksum)
frame_done  out  1  one-cycle pulse after the checksum byte is accepted
drop_cnt  out  8  saturating count of requests ignored while busy

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; out_valid=0, out_data=0, busy=0, frame_done=0, drop_cnt=0.
  - Snapshot contents and checksum are don't-care.
  - Reset mid-frame aborts immediately. No further bytes are sent and no checksum is emitted.
- Frame format, 134 bytes:
  - HEADER.
  - 33 words in order PC, r0..r31, each big-endian (bits 31:24 first): 132 bytes.
  - Checksum: XOR of the 132 payload bytes. HEADER is excluded.
- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM.
  - IDLE: snap_req=1 at edge N loads pc_in and regs_flat into the snapshot and clears the checksum. Go to HEADER. busy=1 and out_valid=1 (out_data=HEADER) from cycle N+1. Zero-cycle capture latency.
  - HEADER: on transfer (out_valid & out_ready), go to PAYLOAD with the byte index at 0.
  - PAYLOAD: 8-bit byte index 0..131; word = idx>>2, byte = 3-(idx&3). Each transfer XORs the byte into the checksum and increments idx. The transfer at idx 131 goes to CHECKSUM.
  - CHECKSUM: out_data = accumulated XOR. On transfer, go to IDLE: busy=0, out_valid=0, frame_done=1 for exactly one cycle.
- Handshake: while out_valid=1 and out_ready=0, out_data must stay stable. out_valid never drops mid-frame except on reset. out_ready is ignored when out_valid=0.
- Snapshot isolation: changes to pc_in or regs_flat after capture must not affect the frame.
- snap_req while busy=1 is ignored, and drop_cnt increments, saturating at 255.
- snap_req in the frame_done cycle is accepted, because the block is IDLE. Back-to-back frames have a one-cycle bubble.
- out_data is registered. out_valid and busy come straight from state flops.

Decomposition:
- Shared package mips_dbg_pkg:
  - HEADER default constant.
  - FRAME_BYTES=134 and PAYLOAD_BYTES=132.
  - State encoding typedef (2-bit).
- One sub-module, snapshot_buffer:
  - 33x32 capture register, loaded on a capture strobe.
  - Combinational byte read port addressed by the 8-bit payload index.
- The FSM, checksum, and drop counter stay in the top level.

Test Plan:
- Zero snapshot: pc_in=0, all regs 0, out_ready=1, pulse snap_req -> A5 followed by 133 bytes 00; frame_done pulses one cycle after the last byte; busy spans exactly 134 cycles.
- Pattern snapshot: pc_in=32'h0040_0000, reg n=n, out_ready=1 -> bytes A5,00,40,00,00,00,00,00,00,00,00,00,01,...,00,00,00,1F, checksum 8'h40.
- Back-pressure: out_ready=0 for 5 cycles while byte index 10 is presented -> out_data and out_valid held constant, and the full frame matches the pattern-snapshot frame.
- Isolation and drops: rewrite all regs to 32'hFFFF_FFFF and pulse snap_req 3 times mid-frame -> frame unchanged; drop_cnt=3. Then 300 further mid-frame requests -> drop_cnt=255.
- Reset abort: assert rst=0 at payload byte 50 -> next cycle out_valid=0, busy=0, drop_cnt=0. A new snap_req yields a fresh, complete frame.
- Back-to-back: snap_req held high continuously -> second frame's header appears two cycles after the first checksum transfer, and drop_cnt counts every request cycle while busy.
